// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS decode constants for the pipelined control block.
//   - opcode / funct field values (including the HI/LO unit instructions)
//   - 3-bit ALUop encodings (zero-extended by users to their ALUop width)
//   - control bundle widths and the decoded control struct
//   - muldiv_op encoding and sequencer state encoding
// Mirrored by the C header mips.h; keep the two in step.
package mips_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_NOP     = 6'h00;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2A;

  // ALUop encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Bundle widths (EX bundle is EX_FIXED_W + ALUop width)
  localparam int EX_FIXED_W = 2;
  localparam int MEM_W      = 2;
  localparam int WB_W       = 2;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } muldiv_op_e;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_BUSY = 1'b1
  } seq_state_e;

  // Decoded control word carried through ID/EX
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic       mem_to_reg;
    logic       jump;
    logic       branch;
    logic       syscall;
    logic       jr;
    logic       jal;
  } ctrl_t;

endpackage

// File: rtl/pipe_muldiv_seq.sv
// pipe_muldiv_seq: occupancy tracker for the multi-cycle HI/LO unit.
// Ports:
//   clk   in  clock
//   reset in  synchronous, active-high
//   start in  a MULT-class instruction is leaving ID this cycle
//   busy  out high for exactly MULDIV_LAT cycles after the start edge
module pipe_muldiv_seq
  import mips_pkg::*;
#(
  parameter int MULDIV_LAT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy
);

  localparam int CW = $clog2(MULDIV_LAT + 1);

  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEQ_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt holds the remaining busy cycles including the current one, so the
  // FSM drops back to IDLE on the edge where cnt goes 1 -> 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          state_d = SEQ_BUSY;
          cnt_d   = CW'(MULDIV_LAT);
        end
      end
      SEQ_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = SEQ_IDLE;
      end
      default: begin
        state_d = SEQ_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == SEQ_BUSY);
  end

endmodule

// File: rtl/pipe_control.sv
// pipe_control: ID-stage control decoder with ID/EX control register,
// load-use and HI/LO interlocks, flush handling and MULT/DIV launch.
// Ports:
//   clk, reset (sync, active-high), instr_id[31:0], id_valid, flush
//   stall (comb), ex_valid, ex_d {RegDst,ALUsrc,ALUop}, mem_d {MemWrite,MemRead},
//   wb_d {RegWrite,MemToReg}, ex_jump/branch/syscall/jr/jal,
//   muldiv_start (1-cycle pulse), muldiv_op, hilo_busy
// Optional: PIPE_CONTROL_ILLEGAL_TRAP_EN adds ex_illegal; unknown
// instructions then advance with ex_valid=1 and an all-zero bundle.
module pipe_control
  import mips_pkg::*;
#(
  parameter int ALUOP_W    = 3,
  parameter int MULDIV_LAT = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [31:0]                     instr_id,
  input  logic                            id_valid,
  input  logic                            flush,
  output logic                            stall,
  output logic                            ex_valid,
  output logic [EX_FIXED_W+ALUOP_W-1:0]   ex_d,
  output logic [MEM_W-1:0]                mem_d,
  output logic [WB_W-1:0]                 wb_d,
  output logic                            ex_jump,
  output logic                            ex_branch,
  output logic                            ex_syscall,
  output logic                            ex_jr,
  output logic                            ex_jal,
`ifdef PIPE_CONTROL_ILLEGAL_TRAP_EN
  output logic                            ex_illegal,
`endif
  output logic                            muldiv_start,
  output logic [1:0]                      muldiv_op,
  output logic                            hilo_busy
);

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt;
  assign opcode = instr_id[31:26];
  assign funct  = instr_id[5:0];
  assign rs     = instr_id[25:21];
  assign rt     = instr_id[20:16];

  ctrl_t      ctrl;
  logic       known, uses_rs, uses_rt, is_muldiv, is_hilo_rd;
  muldiv_op_e md_op;

  always_comb begin
    ctrl       = '0;
    known      = 1'b1;
    uses_rs    = 1'b1;
    uses_rt    = 1'b0;
    is_muldiv  = 1'b0;
    is_hilo_rd = 1'b0;
    md_op      = muldiv_op_e'(funct[1:0]);
    case (opcode)
      OP_RTYPE: begin
        uses_rt = 1'b1;
        case (funct)
          FN_ADD: begin ctrl.reg_dst = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_ADD; end
          FN_SUB: begin ctrl.reg_dst = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SUB; end
          FN_AND: begin ctrl.reg_dst = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_AND; end
          FN_OR:  begin ctrl.reg_dst = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_OR;  end
          FN_SLT: begin ctrl.reg_dst = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SLT; end
          FN_JR:  ctrl.jr = 1'b1;
          FN_SYSCALL: begin ctrl.syscall = 1'b1; uses_rs = 1'b0; end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: is_muldiv = 1'b1;
          FN_MFHI, FN_MFLO: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
            is_hilo_rd     = 1'b1;
            uses_rs        = 1'b0;
          end
          // funct 0 is only accepted as the canonical all-zero NOP
          FN_NOP: begin
            uses_rs = 1'b0;
            known   = (instr_id == 32'h0);
          end
          default: known = 1'b0;
        endcase
      end
      OP_J:   begin ctrl.jump = 1'b1; uses_rs = 1'b0; end
      OP_JAL: begin ctrl.jump = 1'b1; ctrl.jal = 1'b1; ctrl.reg_write = 1'b1; uses_rs = 1'b0; end
      OP_BEQ, OP_BNE: begin ctrl.branch = 1'b1; ctrl.alu_op = ALU_SUB; uses_rt = 1'b1; end
      OP_ADDI, OP_ADDIU: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_ADD; end
      OP_ORI: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_OR; end
      OP_LUI: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_LUI; uses_rs = 1'b0; end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALU_ADD;
        ctrl.mem_read   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_ADD; ctrl.mem_write = 1'b1; uses_rt = 1'b1; end
      default: known = 1'b0;
    endcase
    // Unknown instructions decode to a full bubble and read nothing
    if (!known) begin
      ctrl       = '0;
      uses_rs    = 1'b0;
      uses_rt    = 1'b0;
      is_muldiv  = 1'b0;
      is_hilo_rd = 1'b0;
    end
  end

  ctrl_t ctrl_q;
  logic  ex_valid_q, muldiv_start_q;
  logic  [4:0] ex_rt_q;
  logic  [1:0] muldiv_op_q;
  logic  load_use, hilo_hazard, seq_start, advance;

  // A load in EX writes its rt; any ID source matching it (except $0) waits
  assign load_use = ex_valid_q & ctrl_q.mem_read & id_valid & (ex_rt_q != 5'd0) &
                    ((uses_rs & (rs == ex_rt_q)) | (uses_rt & (rt == ex_rt_q)));
  assign hilo_hazard = hilo_busy & id_valid & (is_muldiv | is_hilo_rd);
  assign stall       = (load_use | hilo_hazard) & ~flush & ~reset;
  assign advance     = id_valid & ~stall & ~flush;
  assign seq_start   = advance & is_muldiv;

  pipe_muldiv_seq #(
    .MULDIV_LAT(MULDIV_LAT)
  ) u_seq (
    .clk  (clk),
    .reset(reset),
    .start(seq_start),
    .busy (hilo_busy)
  );

  always_ff @(posedge clk) begin
    if (reset || flush || stall) begin
      ctrl_q     <= '0;
      ex_valid_q <= 1'b0;
      ex_rt_q    <= 5'd0;
    end else begin
      ctrl_q     <= (id_valid && known) ? ctrl : '0;
`ifdef PIPE_CONTROL_ILLEGAL_TRAP_EN
      ex_valid_q <= id_valid;
`else
      ex_valid_q <= id_valid & known;
`endif
      ex_rt_q    <= rt;
    end
  end

`ifdef PIPE_CONTROL_ILLEGAL_TRAP_EN
  logic ex_illegal_q;
  always_ff @(posedge clk) begin
    if (reset || flush || stall) ex_illegal_q <= 1'b0;
    else                         ex_illegal_q <= id_valid & ~known;
  end
  assign ex_illegal = ex_illegal_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      muldiv_start_q <= 1'b0;
      muldiv_op_q    <= 2'd0;
    end else begin
      muldiv_start_q <= seq_start;
      if (seq_start) muldiv_op_q <= md_op;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_d         = {ctrl_q.reg_dst, ctrl_q.alu_src, ALUOP_W'(ctrl_q.alu_op)};
  assign mem_d        = {ctrl_q.mem_write, ctrl_q.mem_read};
  assign wb_d         = {ctrl_q.reg_write, ctrl_q.mem_to_reg};
  assign ex_jump      = ctrl_q.jump;
  assign ex_branch    = ctrl_q.branch;
  assign ex_syscall   = ctrl_q.syscall;
  assign ex_jr        = ctrl_q.jr;
  assign ex_jal       = ctrl_q.jal;
  assign muldiv_start = muldiv_start_q;
  assign muldiv_op    = muldiv_op_q;

endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: directed plus random stimulus against a mnemonic-level
// reference model of the pipe_control ID/EX stage.
module tb_pipe_control;

  localparam int ALUOP_W = 3;
  localparam int LAT     = 4;

  logic        clk = 1'b0;
  logic        reset, id_valid, flush;
  logic [31:0] instr_id;
  logic        stall, ex_valid, ex_jump, ex_branch, ex_syscall, ex_jr, ex_jal;
  logic [4:0]  ex_d;
  logic [1:0]  mem_d, wb_d, muldiv_op;
  logic        muldiv_start, hilo_busy;
`ifdef PIPE_CONTROL_ILLEGAL_TRAP_EN
  logic        ex_illegal;
`endif

  pipe_control #(.ALUOP_W(ALUOP_W), .MULDIV_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .instr_id(instr_id), .id_valid(id_valid), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .ex_d(ex_d), .mem_d(mem_d), .wb_d(wb_d),
    .ex_jump(ex_jump), .ex_branch(ex_branch), .ex_syscall(ex_syscall), .ex_jr(ex_jr),
    .ex_jal(ex_jal),
`ifdef PIPE_CONTROL_ILLEGAL_TRAP_EN
    .ex_illegal(ex_illegal),
`endif
    .muldiv_start(muldiv_start), .muldiv_op(muldiv_op), .hilo_busy(hilo_busy)
  );

  always #5 clk = ~clk;

  typedef enum {M_UNK, M_NOP, M_LUI, M_J, M_JAL, M_ADDI, M_ADDIU, M_ORI, M_BEQ, M_BNE,
                M_LW, M_SW, M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_JR, M_SYSCALL,
                M_MULT, M_MULTU, M_DIV, M_DIVU, M_MFHI, M_MFLO} mn_e;

  int errors = 0;
  int checks = 0;
  int nstep  = 0;

  // Reference model state: what ID/EX and the HI/LO unit should hold
  logic        m_exv, m_start, m_ill, last_stall;
  logic [13:0] m_ctl;
  logic [4:0]  m_rt;
  logic [1:0]  m_op;
  int          m_busy;

  function automatic mn_e classify(input logic [31:0] i);
    mn_e r;
    r = M_UNK;
    if (i == 32'h0) r = M_NOP;
    else case (i[31:26])
      6'h0F: r = M_LUI;   6'h02: r = M_J;     6'h03: r = M_JAL;
      6'h08: r = M_ADDI;  6'h09: r = M_ADDIU; 6'h0D: r = M_ORI;
      6'h04: r = M_BEQ;   6'h05: r = M_BNE;   6'h23: r = M_LW;   6'h2B: r = M_SW;
      6'h00: case (i[5:0])
        6'h20: r = M_ADD;  6'h22: r = M_SUB;   6'h24: r = M_AND;  6'h25: r = M_OR;
        6'h2A: r = M_SLT;  6'h08: r = M_JR;    6'h0C: r = M_SYSCALL;
        6'h18: r = M_MULT; 6'h19: r = M_MULTU; 6'h1A: r = M_DIV;  6'h1B: r = M_DIVU;
        6'h10: r = M_MFHI; 6'h12: r = M_MFLO;
        default: r = M_UNK;
      endcase
      default: r = M_UNK;
    endcase
    return r;
  endfunction

  // Control word {RegDst,ALUsrc,ALUop[2:0],MemWrite,MemRead,RegWrite,MemToReg,J,B,SYS,JR,JAL}
  function automatic logic [13:0] ctl_of(input mn_e m);
    logic [13:0] c;
    case (m)
      M_LUI:            c = 14'b0_1_011_0_0_1_0_0_0_0_0_0;
      M_J:              c = 14'b0_0_000_0_0_0_0_1_0_0_0_0;
      M_JAL:            c = 14'b0_0_000_0_0_1_0_1_0_0_0_1;
      M_ADDI, M_ADDIU:  c = 14'b0_1_010_0_0_1_0_0_0_0_0_0;
      M_ORI:            c = 14'b0_1_001_0_0_1_0_0_0_0_0_0;
      M_BEQ, M_BNE:     c = 14'b0_0_110_0_0_0_0_0_1_0_0_0;
      M_LW:             c = 14'b0_1_010_0_1_1_1_0_0_0_0_0;
      M_SW:             c = 14'b0_1_010_1_0_0_0_0_0_0_0_0;
      M_ADD:            c = 14'b1_0_010_0_0_1_0_0_0_0_0_0;
      M_SUB:            c = 14'b1_0_110_0_0_1_0_0_0_0_0_0;
      M_AND:            c = 14'b1_0_000_0_0_1_0_0_0_0_0_0;
      M_OR:             c = 14'b1_0_001_0_0_1_0_0_0_0_0_0;
      M_SLT:            c = 14'b1_0_111_0_0_1_0_0_0_0_0_0;
      M_JR:             c = 14'b0_0_000_0_0_0_0_0_0_0_1_0;
      M_SYSCALL:        c = 14'b0_0_000_0_0_0_0_0_0_1_0_0;
      M_MFHI, M_MFLO:   c = 14'b1_0_000_0_0_1_0_0_0_0_0_0;
      default:          c = 14'b0;
    endcase
    return c;
  endfunction

  function automatic logic reads_rs(input mn_e m);
    return !(m inside {M_J, M_JAL, M_LUI, M_MFHI, M_MFLO, M_SYSCALL, M_NOP, M_UNK});
  endfunction

  function automatic logic reads_rt(input mn_e m);
    return m inside {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_JR, M_SYSCALL, M_MULT, M_MULTU,
                     M_DIV, M_DIVU, M_MFHI, M_MFLO, M_BEQ, M_BNE, M_SW};
  endfunction

  function automatic logic [31:0] enc(input mn_e m, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [15:0] imm);
    logic [31:0] r;
    case (m)
      M_NOP:     r = 32'h0;
      M_SYSCALL: r = 32'h0000000C;
      M_LUI:     r = {6'h0F, 5'd0, rt, imm};
      M_J:       r = {6'h02, 10'd0, imm};
      M_JAL:     r = {6'h03, 10'd0, imm};
      M_ADDI:    r = {6'h08, rs, rt, imm};
      M_ADDIU:   r = {6'h09, rs, rt, imm};
      M_ORI:     r = {6'h0D, rs, rt, imm};
      M_BEQ:     r = {6'h04, rs, rt, imm};
      M_BNE:     r = {6'h05, rs, rt, imm};
      M_LW:      r = {6'h23, rs, rt, imm};
      M_SW:      r = {6'h2B, rs, rt, imm};
      M_ADD:     r = {6'h00, rs, rt, rd, 5'd0, 6'h20};
      M_SUB:     r = {6'h00, rs, rt, rd, 5'd0, 6'h22};
      M_AND:     r = {6'h00, rs, rt, rd, 5'd0, 6'h24};
      M_OR:      r = {6'h00, rs, rt, rd, 5'd0, 6'h25};
      M_SLT:     r = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      M_JR:      r = {6'h00, rs, 15'd0, 6'h08};
      M_MULT:    r = {6'h00, rs, rt, 10'd0, 6'h18};
      M_MULTU:   r = {6'h00, rs, rt, 10'd0, 6'h19};
      M_DIV:     r = {6'h00, rs, rt, 10'd0, 6'h1A};
      M_DIVU:    r = {6'h00, rs, rt, 10'd0, 6'h1B};
      M_MFHI:    r = {16'd0, rd, 5'd0, 6'h10};
      M_MFLO:    r = {16'd0, rd, 5'd0, 6'h12};
      default:   r = imm[0] ? {6'h3F, rs, rt, imm} : {6'h00, rs, rt, rd, 5'd0, 6'h3F};
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: check combinational stall, clock, update model, check ID/EX
  task automatic step(input logic [31:0] ins, input logic v, input logic fl, input logic rst);
    mn_e  m;
    logic lu, hl, exp_stall, adv, known, md;
    instr_id = ins; id_valid = v; flush = fl; reset = rst;
    #3;
    m     = classify(ins);
    known = (m != M_UNK);
    md    = m inside {M_MULT, M_MULTU, M_DIV, M_DIVU};
    lu = m_exv && m_ctl[7] && v && (m_rt != 5'd0) &&
         ((reads_rs(m) && ins[25:21] == m_rt) || (reads_rt(m) && ins[20:16] == m_rt));
    hl = (m_busy > 0) && v && (md || m == M_MFHI || m == M_MFLO);
    exp_stall = (lu || hl) && !fl && !rst;
    check("stall", 32'(stall), 32'(exp_stall));
    last_stall = stall;
    @(posedge clk);
    #1;
    if (rst) begin
      m_exv = 0; m_ctl = '0; m_rt = '0; m_start = 0; m_op = '0; m_ill = 0; m_busy = 0;
    end else begin
      adv     = v && !exp_stall && !fl;
      m_start = adv && md;
      m_busy  = m_start ? LAT : ((m_busy > 0) ? m_busy - 1 : 0);
      if (m_start) m_op = (m == M_MULT) ? 2'd0 : (m == M_MULTU) ? 2'd1 : (m == M_DIV) ? 2'd2 : 2'd3;
`ifdef PIPE_CONTROL_ILLEGAL_TRAP_EN
      m_exv = adv;
      m_ill = adv && !known;
`else
      m_exv = adv && known;
      m_ill = 1'b0;
`endif
      m_ctl = (adv && known) ? ctl_of(m) : 14'b0;
      m_rt  = ins[20:16];
    end
    check("ex_valid", 32'(ex_valid), 32'(m_exv));
    check("ex_d", 32'(ex_d), 32'(m_ctl[13:9]));
    check("mem_d", 32'(mem_d), 32'(m_ctl[8:7]));
    check("wb_d", 32'(wb_d), 32'(m_ctl[6:5]));
    check("flags", 32'({ex_jump, ex_branch, ex_syscall, ex_jr, ex_jal}), 32'(m_ctl[4:0]));
    check("muldiv_start", 32'(muldiv_start), 32'(m_start));
    check("muldiv_op", 32'(muldiv_op), 32'(m_op));
    check("hilo_busy", 32'(hilo_busy), 32'(m_busy > 0));
`ifdef PIPE_CONTROL_ILLEGAL_TRAP_EN
    check("ex_illegal", 32'(ex_illegal), 32'(m_ill));
`endif
    nstep++;
    $display("step %0d instr=%h v=%b fl=%b rst=%b | stall=%b exv=%b ex_d=%b mem=%b wb=%b start=%b busy=%b",
             nstep, ins, v, fl, rst, last_stall, ex_valid, ex_d, mem_d, wb_d, muldiv_start, hilo_busy);
  endtask

  localparam logic [31:0] I_LW   = 32'h8C080000;
  localparam logic [31:0] I_ADD  = 32'h01084820;
  localparam logic [31:0] I_ADDI = 32'h21490001;
  localparam logic [31:0] I_MULT = 32'h01090018;
  localparam logic [31:0] I_MFLO = 32'h00005012;
  localparam logic [31:0] I_UNK  = 32'hFC000000;

  initial begin
    int stall_cycles;
    mn_e m;
    m_exv = 0; m_ctl = '0; m_rt = '0; m_start = 0; m_op = '0; m_ill = 0; m_busy = 0;
    last_stall = 0;
    instr_id = '0; id_valid = 0; flush = 0; reset = 1;
    @(posedge clk); #1;

    // Reset: every output low
    step(32'h0, 0, 0, 1);
    step(32'h0, 0, 0, 1);
    check("reset_ex_valid", 32'(ex_valid), 32'd0);

    // Load-use: one stall, one bubble, then ADD issues
    step(I_LW, 1, 0, 0);
    step(I_ADD, 1, 0, 0);
    check("lu_stall", 32'(last_stall), 32'd1);
    check("lu_bubble", 32'(ex_valid), 32'd0);
    step(I_ADD, 1, 0, 0);
    check("lu_ex_d", 32'(ex_d), 32'b10010);
    check("lu_wb_d", 32'(wb_d), 32'b10);

    // No hazard: ADDI does not read the loaded register
    step(I_LW, 1, 0, 0);
    step(I_ADDI, 1, 0, 0);
    check("nohaz_stall", 32'(last_stall), 32'd0);
    check("nohaz_ex_d", 32'(ex_d), 32'b01010);

    // MULT then MFLO: start pulse, LAT busy cycles, LAT stall cycles
    step(I_MULT, 1, 0, 0);
    check("mult_start", 32'(muldiv_start), 32'd1);
    check("mult_op", 32'(muldiv_op), 32'd0);
    stall_cycles = 0;
    for (int k = 0; k < 10; k++) begin
      step(I_MFLO, 1, 0, 0);
      if (!last_stall) break;
      stall_cycles++;
    end
    check("mflo_stall_cycles", 32'(stall_cycles), 32'(LAT));
    check("mflo_wb_d", 32'(wb_d), 32'b10);

    // Flush with MULT in ID: nothing starts
    step(I_MULT, 1, 1, 0);
    check("flush_no_start", 32'(muldiv_start), 32'd0);
    check("flush_bubble", 32'(ex_valid), 32'd0);
    // Flush overrides a load-use hazard
    step(I_LW, 1, 0, 0);
    step(I_ADD, 1, 1, 0);
    check("flush_lu_stall", 32'(last_stall), 32'd0);
    check("flush_lu_bubble", 32'(ex_valid), 32'd0);

    // Reset two cycles into a MULT, then MFLO issues without stall
    step(I_MULT, 1, 0, 0);
    step(32'h0, 1, 0, 0);
    step(32'h0, 1, 0, 1);
    check("rst_mid_busy", 32'(hilo_busy), 32'd0);
    step(I_MFLO, 1, 0, 0);
    check("rst_mflo_stall", 32'(last_stall), 32'd0);

    // Unknown opcode
    step(I_UNK, 1, 0, 0);
`ifdef PIPE_CONTROL_ILLEGAL_TRAP_EN
    check("unk_ex_valid", 32'(ex_valid), 32'd1);
    check("unk_illegal", 32'(ex_illegal), 32'd1);
    step(I_UNK, 1, 1, 0);
    check("unk_flush_clear", 32'(ex_illegal), 32'd0);
`else
    check("unk_ex_valid", 32'(ex_valid), 32'd0);
    check("unk_ex_d", 32'(ex_d), 32'd0);
`endif

    // Random traffic with small register numbers to provoke hazards
    for (int n = 0; n < 300; n++) begin
      m = mn_e'($urandom_range(0, 24));
      step(enc(m, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 16'($urandom)),
           ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 8),
           ($urandom_range(0, 99) < 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
